// File: rtl/multicycle_ctrl_if.sv
// Memory handshake and datapath status bundle between the multi-cycle sequencer and its datapath.
interface multicycle_ctrl_if;
  logic [3:0] opCode;
  logic       zero;
  logic       mem_ready;
  logic       MemRead;
  logic       MemWrite;
  logic       IorD;

  modport master (
    input  opCode, zero, mem_ready,
    output MemRead, MemWrite, IorD
  );

  modport slave (
    output opCode, zero, mem_ready,
    input  MemRead, MemWrite, IorD
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-ready stalls and a sticky FAULT trap.
// Optional performance counters (cyc_cnt/ret_cnt) are built only when CTRL_PERF_EN is defined.
module multicycle_ctrl #(
  parameter int TMO_W = 4
`ifdef CTRL_PERF_EN
  , parameter int PERF_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_if.master    bus,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 IRWrite,
  output logic                 MemToReg,
  output logic                 RegDst,
  output logic                 RegWrite,
  output logic                 ExtOp,
  output logic                 AluSrcA,
  output logic [1:0]           AluSrcB,
  output logic [2:0]           AluOp,
  output logic [1:0]           PCSource,
  output logic                 fault,
  output logic [3:0]           state_o
`ifdef CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]    cyc_cnt,
  output logic [PERF_W-1:0]    ret_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MADDR  = 4'd2,
    S_MRD    = 4'd3,
    S_MWB    = 4'd4,
    S_MWR    = 4'd5,
    S_REXE   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JMP    = 4'd9,
    S_FAULT  = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       ext_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       fault;
  } ctrl_t;

  localparam logic [TMO_W-1:0] CNT_MAX = '1;
  localparam logic [TMO_W-1:0] CNT_ONE = 1;

  state_t           state;
  state_t           nxt;
  logic             sw;
  logic             sw_nxt;
  logic [TMO_W-1:0] cnt;
  logic             wait_full;
  logic             mem_state;
  logic             fetch_ack;
  ctrl_t            ctrl_q;

  // Strobe pattern for each state; MADDR needs the lw/sw flag to pick the ALU op.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic is_sw);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = 3'b001;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b10;
        c.ext_op    = 1'b1;
        c.alu_op    = 3'b001;
      end
      S_MADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.ext_op    = 1'b1;
        c.alu_op    = is_sw ? 3'b010 : 3'b001;
      end
      S_MRD: begin
        c.mem_read = 1'b1;
        c.ior_d    = 1'b1;
      end
      S_MWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MWR: begin
        c.mem_write = 1'b1;
        c.ior_d     = 1'b1;
      end
      S_REXE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b000;
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 3'b011;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        c.alu_op    = 3'b100;
      end
      S_FAULT: c.fault = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign wait_full = (cnt == CNT_MAX);
  assign mem_state = (state == S_FETCH) || (state == S_MRD) || (state == S_MWR);

  // A memory state exits on ready; ready in the last permitted wait cycle still beats the timeout.
  always_comb begin
    nxt    = state;
    sw_nxt = sw;
    case (state)
      S_FETCH:  nxt = bus.mem_ready ? S_DECODE : (wait_full ? S_FAULT : S_FETCH);
      S_DECODE: begin
        sw_nxt = (bus.opCode == 4'b0010);
        case (bus.opCode)
          4'b0000:          nxt = S_REXE;
          4'b0001, 4'b0010: nxt = S_MADDR;
          4'b0011:          nxt = S_BEQ;
          4'b0100:          nxt = S_JMP;
          default:          nxt = S_FAULT;
        endcase
      end
      S_REXE:   nxt = S_RWB;
      S_RWB:    nxt = S_FETCH;
      S_MADDR:  nxt = sw ? S_MWR : S_MRD;
      S_MRD:    nxt = bus.mem_ready ? S_MWB : (wait_full ? S_FAULT : S_MRD);
      S_MWB:    nxt = S_FETCH;
      S_MWR:    nxt = bus.mem_ready ? S_FETCH : (wait_full ? S_FAULT : S_MWR);
      S_BEQ:    nxt = S_FETCH;
      S_JMP:    nxt = S_FETCH;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_FAULT;
    endcase
  end

  // Strobes are registered alongside the state they belong to, so they never glitch on inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      sw     <= 1'b0;
      cnt    <= '0;
      ctrl_q <= decode_ctrl(S_FETCH, 1'b0);
    end else begin
      state  <= nxt;
      sw     <= sw_nxt;
      cnt    <= (mem_state && (nxt == state)) ? cnt + CNT_ONE : '0;
      ctrl_q <= decode_ctrl(nxt, sw_nxt);
    end
  end

  // The fetched word is only valid in the cycle memory signals ready, so IR/PC capture follows it directly.
  assign fetch_ack    = (state == S_FETCH) && bus.mem_ready;

  assign PCWrite      = ctrl_q.pc_write | fetch_ack;
  assign PCWriteCond  = ctrl_q.pc_write_cond;
  assign IRWrite      = fetch_ack;
  assign bus.IorD     = ctrl_q.ior_d;
  assign bus.MemRead  = ctrl_q.mem_read;
  assign bus.MemWrite = ctrl_q.mem_write;
  assign MemToReg     = ctrl_q.mem_to_reg;
  assign RegDst       = ctrl_q.reg_dst;
  assign RegWrite     = ctrl_q.reg_write;
  assign ExtOp        = ctrl_q.ext_op;
  assign AluSrcA      = ctrl_q.alu_src_a;
  assign AluSrcB      = ctrl_q.alu_src_b;
  assign AluOp        = ctrl_q.alu_op;
  assign PCSource     = ctrl_q.pc_source;
  assign fault        = ctrl_q.fault;
  assign state_o      = state;

`ifdef CTRL_PERF_EN
  localparam logic [PERF_W-1:0] PERF_ONE = 1;

  logic retire;

  // An instruction retires in its last state; a store only once memory accepts it.
  assign retire = (state == S_RWB) || (state == S_MWB) || (state == S_BEQ) ||
                  (state == S_JMP) || ((state == S_MWR) && bus.mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (state != S_FAULT) cyc_cnt <= cyc_cnt + PERF_ONE;
      if (retire)           ret_cnt <= ret_cnt + PERF_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle expected trace built from instruction-level rules.
module tb_multicycle_ctrl;

  typedef struct {
    logic       rst;
    logic [3:0] op;
    logic       zero;
    logic       ready;
    int         state;
    logic       sw;
    int         pin;
  } vec_t;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       extOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSource;
    logic       fault;
    logic [3:0] state;
  } outs_t;

  localparam int PERF_BITS = 4;

  logic       clk;
  logic       rst_n;
  logic       PCWrite, PCWriteCond, IRWrite, MemToReg, RegDst, RegWrite, ExtOp, AluSrcA, fault;
  logic [1:0] AluSrcB, PCSource;
  logic [2:0] AluOp;
  logic [3:0] state_o;
`ifdef CTRL_PERF_EN
  logic [PERF_BITS-1:0] cyc_cnt, ret_cnt;
`endif

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(
    .TMO_W(4)
`ifdef CTRL_PERF_EN
    , .PERF_W(PERF_BITS)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite), .ExtOp(ExtOp),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp), .PCSource(PCSource),
    .fault(fault), .state_o(state_o)
`ifdef CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t vecs[$];
  vec_t cur;
  logic curValid = 1'b0;
  int   totalChecks = 0;
  int   badChecks = 0;
  int   cycleNo = 0;
  int   beqTaken = 0;
  int   mCyc = 0;
  int   mRet = 0;

  task automatic checkValue(input string name, input int actual, input int expected);
    totalChecks++;
    if (actual != expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushVec(input logic rst, input logic [3:0] op, input logic z, input logic r,
                         input int st, input logic sw);
    vec_t v;
    v.rst = rst; v.op = op; v.zero = z; v.ready = r; v.state = st; v.sw = sw; v.pin = 0;
    vecs.push_back(v);
  endtask

  task automatic addReset();
    pushVec(1'b1, 4'hF, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // One instruction at the step level: fetch with stalls, decode, then the opcode's own step list.
  task automatic addInstr(input logic [3:0] op, input logic z, input int fw, input int mw,
                          output int cycles);
    int n0;
    n0 = vecs.size();
    for (int i = 0; i < fw; i++) pushVec(1'b0, 4'hF, z, 1'b0, 0, 1'b0);
    pushVec(1'b0, 4'hF, z, 1'b1, 0, 1'b0);
    pushVec(1'b0, op, z, 1'b1, 1, 1'b0);
    case (op)
      4'b0000: begin
        pushVec(1'b0, 4'hF, z, 1'b1, 6, 1'b0);
        pushVec(1'b0, 4'hF, z, 1'b1, 7, 1'b0);
      end
      4'b0001: begin
        pushVec(1'b0, 4'hF, z, 1'b1, 2, 1'b0);
        for (int i = 0; i < mw; i++) pushVec(1'b0, 4'hF, z, 1'b0, 3, 1'b0);
        pushVec(1'b0, 4'hF, z, 1'b1, 3, 1'b0);
        pushVec(1'b0, 4'hF, z, 1'b1, 4, 1'b0);
      end
      4'b0010: begin
        pushVec(1'b0, 4'hF, z, 1'b1, 2, 1'b1);
        for (int i = 0; i < mw; i++) pushVec(1'b0, 4'hF, z, 1'b0, 5, 1'b0);
        pushVec(1'b0, 4'hF, z, 1'b1, 5, 1'b0);
      end
      4'b0011: pushVec(1'b0, 4'hF, z, 1'b1, 8, 1'b0);
      4'b0100: pushVec(1'b0, 4'hF, z, 1'b1, 9, 1'b0);
      default: pushVec(1'b0, 4'hF, z, 1'b1, 15, 1'b0);
    endcase
    cycles = vecs.size() - n0;
  endtask

  function automatic outs_t expOuts(input vec_t v);
    outs_t o;
    o = '0;
    o.state = 4'(v.state);
    case (v.state)
      0:  begin o.memRead = 1; o.aluSrcB = 2'b01; o.aluOp = 3'b001;
                o.irWrite = v.ready; o.pcWrite = v.ready; end
      1:  begin o.aluSrcB = 2'b10; o.extOp = 1; o.aluOp = 3'b001; end
      2:  begin o.aluSrcA = 1; o.aluSrcB = 2'b10; o.extOp = 1;
                o.aluOp = v.sw ? 3'b010 : 3'b001; end
      3:  begin o.memRead = 1; o.iorD = 1; end
      4:  begin o.regWrite = 1; o.memToReg = 1; end
      5:  begin o.memWrite = 1; o.iorD = 1; end
      6:  begin o.aluSrcA = 1; o.aluOp = 3'b000; end
      7:  begin o.regWrite = 1; o.regDst = 1; end
      8:  begin o.aluSrcA = 1; o.aluOp = 3'b011; o.pcWriteCond = 1; o.pcSource = 2'b01; end
      9:  begin o.pcWrite = 1; o.pcSource = 2'b10; o.aluOp = 3'b100; end
      15: o.fault = 1;
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst_n         = !v.rst;
    bus.opCode    = v.op;
    bus.zero      = v.zero;
    bus.mem_ready = v.ready;
    cur           = v;
    curValid      = 1'b1;
  endtask

  task automatic checkOutput();
    outs_t act, exp;
    act = {PCWrite, PCWriteCond, bus.IorD, IRWrite, bus.MemRead, bus.MemWrite, MemToReg,
           RegDst, RegWrite, ExtOp, AluSrcA, AluSrcB, AluOp, PCSource, fault, state_o};
    exp = expOuts(cur);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL outputs cycle=%0d: got %h, expected %h (state got %0d, expected %0d)",
               cycleNo, act, exp, state_o, cur.state);
    end
    if (cur.state == 8 && PCWriteCond && bus.zero) beqTaken++;
`ifdef CTRL_PERF_EN
    if (cur.rst) begin mCyc = 0; mRet = 0; end
    checkValue("cyc_cnt", int'(cyc_cnt), mCyc);
    checkValue("ret_cnt", int'(ret_cnt), mRet);
    if (cur.pin == 1) begin
      checkValue("perf_ret_after_5j", int'(ret_cnt), 5);
      checkValue("perf_cyc_after_5j", int'(cyc_cnt), 15);
    end
    if (cur.pin == 2) checkValue("perf_cyc_wrap", int'(cyc_cnt), 1);
    if (!cur.rst) begin
      if (cur.state != 15) mCyc = (mCyc + 1) % (1 << PERF_BITS);
      if (cur.state inside {4, 7, 8, 9} || (cur.state == 5 && cur.ready))
        mRet = (mRet + 1) % (1 << PERF_BITS);
    end
`endif
    cycleNo++;
  endtask

  // Inputs change on the falling edge; outputs are compared shortly after, well before the next rise.
  always @(negedge clk) begin
    #2;
    if (curValid) checkOutput();
  end

  initial begin
    int n, base;
    rst_n = 1'b0;
    bus.opCode = 4'h0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    addReset(); addReset();
    addInstr(4'b0000, 1'b0, 0, 0, n); checkValue("cpi_r", n, 4);
    addInstr(4'b0001, 1'b0, 0, 3, n); checkValue("cpi_lw_3wait", n, 8);
    addInstr(4'b0010, 1'b0, 2, 1, n); checkValue("cpi_sw_3wait", n, 7);
    addInstr(4'b0011, 1'b1, 0, 0, n); checkValue("cpi_beq_taken", n, 3);
    addInstr(4'b0011, 1'b0, 0, 0, n); checkValue("cpi_beq_not", n, 3);
    addInstr(4'b0100, 1'b0, 0, 0, n); checkValue("cpi_j", n, 3);

    // Reset while a load is waiting in MRD.
    pushVec(1'b0, 4'hF, 1'b0, 1'b1, 0, 1'b0);
    pushVec(1'b0, 4'b0001, 1'b0, 1'b1, 1, 1'b0);
    pushVec(1'b0, 4'hF, 1'b0, 1'b1, 2, 1'b0);
    pushVec(1'b0, 4'hF, 1'b0, 1'b0, 3, 1'b0);
    pushVec(1'b0, 4'hF, 1'b0, 1'b0, 3, 1'b0);
    addReset();
    addInstr(4'b0000, 1'b0, 0, 0, n);

    // Illegal opcodes trap and stay trapped whatever the inputs do.
    addInstr(4'b0111, 1'b0, 0, 0, n);
    for (int i = 0; i < 19; i++) pushVec(1'b0, 4'(i), 1'(i % 3), 1'(i % 2), 15, 1'b0);
    addReset();
    addInstr(4'b0101, 1'b0, 1, 0, n);
    pushVec(1'b0, 4'h0, 1'b0, 1'b1, 15, 1'b0);
    addReset();

    // Fetch timeout, then the same stall rescued by ready in the last permitted cycle.
    for (int i = 0; i < 16; i++) pushVec(1'b0, 4'hF, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) pushVec(1'b0, 4'hF, 1'b0, 1'(i % 2), 15, 1'b0);
    addReset();
    addInstr(4'b0100, 1'b0, 15, 0, n); checkValue("cpi_j_15wait", n, 18);

    // Load timeout in MRD.
    pushVec(1'b0, 4'hF, 1'b0, 1'b1, 0, 1'b0);
    pushVec(1'b0, 4'b0001, 1'b0, 1'b1, 1, 1'b0);
    pushVec(1'b0, 4'hF, 1'b0, 1'b1, 2, 1'b0);
    for (int i = 0; i < 16; i++) pushVec(1'b0, 4'hF, 1'b0, 1'b0, 3, 1'b0);
    pushVec(1'b0, 4'hF, 1'b0, 1'b0, 15, 1'b0);
    pushVec(1'b0, 4'hF, 1'b0, 1'b1, 15, 1'b0);
    addReset();

    // Six jumps from reset; performance pins sit after 15 and 17 cycles.
    base = vecs.size();
    for (int i = 0; i < 6; i++) addInstr(4'b0100, 1'b0, 0, 0, n);
    vecs[base + 15].pin = 1;
    vecs[base + 17].pin = 2;

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
    end
    @(negedge clk);
    curValid = 1'b0;
    #3;
    checkValue("beq_pc_loads", beqTaken, 1);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
